tx_interface: RTL and testbench
===============================

// Module: tx_interface
// PURPOSE
//   Transmit-side counterpart of the UART command interface. When the receive side
//   has collected operand A, operand B and the opcode, it pulses i_start.
//   This block then latches the ALU result and hands it to the UART transmitter.
//   Results wider than one UART byte are split into bytes, MSB byte first, using a
//   start/done handshake with the transmitter.
// PARAMETERS
//   NB_DATA    8   UART byte width (transmitter data bus)
//   NB_RESULT  8   ALU result width; must be an integer multiple of NB_DATA
//   N_BYTES    --  localparam = NB_RESULT/NB_DATA; byte counter sized to hold N_BYTES-1 (min 1 bit)
// PORTS
//   i_clock     in   1          clock, all logic on rising edge
//   i_reset     in   1          synchronous, active-high reset
//   i_start     in   1          one-cycle request; result in i_result is valid this cycle
//   i_result    in   NB_RESULT  ALU result, raw bits (sign not interpreted)
//   i_tx_done   in   1          UART transmitter finished current byte (one-cycle pulse)
//   o_tx_start  out  1          one-cycle pulse: transmitter must start sending o_tx_data
//   o_tx_data   out  NB_DATA    byte being sent; stable from o_tx_start until i_tx_done
//   o_busy      out  1          high in every state except IDLE
//   o_done      out  1          one-cycle pulse: all N_BYTES bytes sent
// BEHAVIOUR
//   - Reset (i_reset is synchronous, active-high; clock is i_clock): state=IDLE,
//     shift reg=0, byte count=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0.
//   - Reset has priority over all other inputs. Reset in any state aborts the transfer.
//     No o_done is issued and the remaining bytes are dropped.
//   - FSM states: IDLE, SEND, WAIT, DONE. All outputs are registered or decoded from state.
//   - IDLE: if i_start=1, latch i_result into the shift reg, clear the byte count, go to SEND.
//     i_tx_done is ignored in IDLE.
//   - SEND (exactly 1 cycle): o_tx_start=1 and o_tx_data=shift_reg[NB_RESULT-1 -: NB_DATA].
//     Then go to WAIT. i_tx_done is ignored in SEND.
//   - WAIT: o_tx_data held; wait indefinitely (no timeout). On i_tx_done:
//       byte count == N_BYTES-1 -> DONE
//       else shift reg <<= NB_DATA, byte count+1 -> SEND
//   - DONE (exactly 1 cycle): o_done=1, then go to IDLE.
//   - o_busy=1 in SEND, WAIT and DONE.
//   - Latency:
//       i_start at cycle t -> o_tx_start at t+1
//       i_tx_done at cycle w -> next o_tx_start at w+1, or o_done at w+1
//       new i_start accepted from w+2
//   - i_start while o_busy=1 is ignored (including in DONE). The latched result is
//     unaffected by later changes of i_result.
//   - After DONE, o_tx_data keeps the last byte sent until the next SEND.
//   - Byte count never wraps: it is cleared on every accepted i_start.
// TESTING
//   1 NB_RESULT=8, i_result=8'hA5, i_start at t -> o_tx_start=1 at t+1 only,
//     o_tx_data=A5; i_tx_done at t+11 -> o_done=1 at t+12 only, o_busy=0 at t+13.
//   2 NB_RESULT=16, i_result=16'h1234 -> first pulse sends 8'h12; i_tx_done at w ->
//     second o_tx_start at w+1 sending 8'h34; o_done after the 2nd i_tx_done only.
//   3 i_start with result 8'h3C while in WAIT (and again in the DONE cycle) -> ignored;
//     only the original byte is sent and exactly one o_done occurs.
//   4 i_reset during WAIT of byte 1 (NB_RESULT=16) -> next cycle all outputs 0, no o_done;
//     a following i_start with 16'hBEEF sends BE then EF correctly.
//   5 Spurious i_tx_done in IDLE and coincident with the SEND cycle -> no state change;
//     the transfer completes only on the i_tx_done seen in WAIT.
//   6 i_start held high continuously with i_tx_done returned 5 cycles after each
//     o_tx_start -> one transfer per start window, no start accepted while o_busy=1;
//     o_tx_data never changes between o_tx_start and i_tx_done.

Source files
------------

// File: rtl/tx_interface.sv
// Purpose : hands a latched ALU result to the UART transmitter, MSB byte first.
// Latency : i_start -> o_tx_start next cycle; i_tx_done -> next o_tx_start or o_done next cycle.
// Backpressure: one byte in flight; waits indefinitely for i_tx_done, drops i_start while busy.
//
// Ports:
//   i_clock, i_reset     clock and synchronous active-high reset
//   i_start, i_result    one-cycle request carrying the result to send
//   i_tx_done            transmitter finished the current byte
//   o_tx_start/o_tx_data start pulse and byte for the transmitter
//   o_busy, o_done       transfer in progress / one-cycle completion pulse
module tx_interface #(
   parameter int NB_DATA   = 8,
   parameter int NB_RESULT = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [NB_RESULT-1:0] i_result,
   input  logic                 i_tx_done,
   output logic                 o_tx_start,
   output logic [NB_DATA-1:0]   o_tx_data,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int N_BYTES = NB_RESULT / NB_DATA;
   localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NB_RESULT-1:0] shift_q, shift_d;
   logic [NB_RESULT-1:0] shift_nxt;
   logic [NB_CNT-1:0]    cnt_q, cnt_d;
   logic [NB_DATA-1:0]   data_q, data_d;
   logic                 last_byte;

   assign shift_nxt = shift_q << NB_DATA;
   assign last_byte = (cnt_q == LAST_CNT);

   // State and datapath registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_start) state_d = ST_SEND;
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: if (i_tx_done) state_d = last_byte ? ST_DONE : ST_SEND;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values. The output byte register is loaded on the way
   // into SEND so it already shows the top byte during the SEND cycle and
   // keeps it through WAIT, DONE and IDLE until the next SEND.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               shift_d = i_result;
               cnt_d   = '0;
               data_d  = i_result[NB_RESULT-1 -: NB_DATA];
            end
         end
         ST_WAIT: begin
            if (i_tx_done && !last_byte) begin
               shift_d = shift_nxt;
               cnt_d   = cnt_q + NB_CNT'(1);
               data_d  = shift_nxt[NB_RESULT-1 -: NB_DATA];
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state or taken straight from registers
   always_comb begin
      o_tx_start = (state_q == ST_SEND);
      o_done     = (state_q == ST_DONE);
      o_busy     = (state_q != ST_IDLE);
      o_tx_data  = data_q;
   end

endmodule

// File: tb/tb_tx_interface.sv
module tb_tx_interface;

   localparam int END_CYC  = 3200;
   localparam int END_STIM = 3000;
   localparam int HOLD_LO  = 1500;
   localparam int HOLD_HI  = 2500;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // index 0: NB_RESULT=8 instance, index 1: NB_RESULT=16 instance
   logic [1:0]  rst, start, txd, tx_start, busy, done;
   logic [15:0] res     [2];
   logic [7:0]  tx_data [2];

   tx_interface #(.NB_DATA(8), .NB_RESULT(8)) u_dut8 (
      .i_clock(clk), .i_reset(rst[0]), .i_start(start[0]), .i_result(res[0][7:0]),
      .i_tx_done(txd[0]), .o_tx_start(tx_start[0]), .o_tx_data(tx_data[0]),
      .o_busy(busy[0]), .o_done(done[0]));

   tx_interface #(.NB_DATA(8), .NB_RESULT(16)) u_dut16 (
      .i_clock(clk), .i_reset(rst[1]), .i_start(start[1]), .i_result(res[1]),
      .i_tx_done(txd[1]), .o_tx_start(tx_start[1]), .o_tx_data(tx_data[1]),
      .o_busy(busy[1]), .o_done(done[1]));

   typedef struct {
      int         dut;
      int         cyc;
      bit         is_done;
      logic [7:0] dat;
   } ev_t;

   ev_t evq[$];
   int  txd_map[int];   // window of a scheduled i_tx_done -> window of the accepting start
   int  send_map[int];  // window of an expected o_tx_start -> window of the accepting start

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;

   int  idle_from  [2];
   int  last_reset [2];
   int  busy_lo    [2];
   int  busy_hi    [2];
   int  n_acc      [2];
   logic [7:0] exp_data [2];
   bit  rst_prev   [2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int key(input int d, input int c);
      return d * 1000000 + c;
   endfunction

   function automatic logic [15:0] dir_val(input int d, input int i);
      if (d == 0) return (i == 0) ? 16'h00A5 : 16'h003C;
      else        return (i == 0) ? 16'h1234 : 16'hBEEF;
   endfunction

   // An accepted start at window k fixes the whole transfer schedule:
   // byte i goes out at s_i, its done returns dly later, the next byte
   // (or the completion pulse) follows one window after that.
   task automatic accept(input int d, input int k, input logic [15:0] v);
      int nb;
      int s;
      int dly;
      ev_t e;
      nb = d + 1;
      s  = k + 1;
      for (int i = 0; i < nb; i++) begin
         e.dut = d; e.cyc = s; e.is_done = 1'b0;
         e.dat = 8'(v >> (8 * (nb - 1 - i)));
         evq.push_back(e);
         send_map[key(d, s)] = k;
         dly = (k >= HOLD_LO && k < HOLD_HI) ? 5 : $urandom_range(1, 12);
         txd_map[key(d, s + dly)] = k;
         s = s + dly + 1;
      end
      e.dut = d; e.cyc = s; e.is_done = 1'b1; e.dat = 8'h00;
      evq.push_back(e);
      busy_lo[d]   = k + 1;
      busy_hi[d]   = s;
      idle_from[d] = s + 1;
      n_acc[d]++;
   endtask

   task automatic drive(input int d, input int k);
      bit do_rst;
      bit sched;
      bit safe;
      do_rst = (k < 3) || (k > 20 && k < END_STIM && $urandom_range(0, 199) == 0);
      rst[d] = do_rst;
      res[d] = 16'($urandom);
      if (k >= END_STIM)                    start[d] = 1'b0;
      else if (k >= HOLD_LO && k < HOLD_HI) start[d] = 1'b1;
      else                                  start[d] = ($urandom_range(0, 99) < 25);
      if (do_rst) begin
         txd[d] = 1'($urandom_range(0, 1));
         last_reset[d] = k;
         for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].dut == d && evq[i].cyc > k) evq.delete(i);
         if (busy_hi[d] > k) busy_hi[d] = k;
         idle_from[d] = k + 1;
      end else begin
         sched = txd_map.exists(key(d, k)) && txd_map[key(d, k)] > last_reset[d];
         // a stray done is harmless while idle or during the single SEND cycle
         safe  = (k >= idle_from[d]) ||
                 (send_map.exists(key(d, k)) && send_map[key(d, k)] > last_reset[d]);
         txd[d] = sched || (safe && $urandom_range(0, 9) == 0);
         if (start[d] && k >= idle_from[d]) begin
            if (n_acc[d] < 2) res[d] = dir_val(d, n_acc[d]);
            accept(d, k, res[d]);
         end
      end
   endtask

   // Stimulus: window k spans posedge k to posedge k+1
   initial begin
      for (int d = 0; d < 2; d++) begin
         idle_from[d] = 0; last_reset[d] = -1;
         busy_lo[d] = 0; busy_hi[d] = -1; n_acc[d] = 0;
      end
      for (int k = 0; k <= END_CYC; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         drive(0, k);
         drive(1, k);
      end
   end

   task automatic check(input int d, input int k);
      int  idx;
      bit  exp_busy;
      if (rst_prev[d]) begin
         checks++;
         if ({tx_start[d], done[d], busy[d], tx_data[d]} != 11'd0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d cyc %0d got start=%0b done=%0b busy=%0b data=%02h want all 0",
                     d, k, tx_start[d], done[d], busy[d], tx_data[d]);
         end
         exp_data[d] = 8'h00;
      end
      idx = -1;
      for (int i = 0; i < evq.size(); i++)
         if (idx < 0 && evq[i].dut == d) idx = i;
      while (idx >= 0 && evq[idx].cyc < k) begin
         checks++; errors++;
         $display("FAIL missed_event dut%0d cyc %0d got none want %s at cyc %0d",
                  d, k, evq[idx].is_done ? "done" : "tx_start", evq[idx].cyc);
         evq.delete(idx);
         idx = -1;
         for (int i = 0; i < evq.size(); i++)
            if (idx < 0 && evq[i].dut == d) idx = i;
      end
      if (idx >= 0 && evq[idx].cyc == k) begin
         checks++;
         if (!evq[idx].is_done) begin
            if (!(tx_start[d] && !done[d] && tx_data[d] == evq[idx].dat)) begin
               errors++;
               $display("FAIL tx_start_byte dut%0d cyc %0d got start=%0b done=%0b data=%02h want start=1 done=0 data=%02h",
                        d, k, tx_start[d], done[d], tx_data[d], evq[idx].dat);
            end
            exp_data[d] = evq[idx].dat;
         end else if (!(done[d] && !tx_start[d])) begin
            errors++;
            $display("FAIL done_pulse dut%0d cyc %0d got done=%0b start=%0b want done=1 start=0",
                     d, k, done[d], tx_start[d]);
         end
         evq.delete(idx);
      end else begin
         checks++;
         if (tx_start[d] || done[d]) begin
            errors++;
            $display("FAIL spurious_pulse dut%0d cyc %0d got start=%0b done=%0b want 0 0",
                     d, k, tx_start[d], done[d]);
         end
      end
      checks++;
      if (tx_data[d] !== exp_data[d]) begin
         errors++;
         $display("FAIL data_hold dut%0d cyc %0d got %02h want %02h", d, k, tx_data[d], exp_data[d]);
      end
      exp_busy = (k >= busy_lo[d] && k <= busy_hi[d]);
      checks++;
      if (busy[d] !== exp_busy) begin
         errors++;
         $display("FAIL busy dut%0d cyc %0d got %0b want %0b", d, k, busy[d], exp_busy);
      end
      rst_prev[d] = rst[d];
   endtask

   // Monitor: samples each window on the falling edge
   initial begin
      rst_prev[0] = 1'b1; rst_prev[1] = 1'b1;
      exp_data[0] = 8'h00; exp_data[1] = 8'h00;
      for (int k = 1; k <= END_CYC; k++) begin
         @(negedge clk);
         check(0, k);
         check(1, k);
      end
      while (evq.size() > 0) begin
         checks++; errors++;
         $display("FAIL missing_event dut%0d got none want %s at cyc %0d",
                  evq[0].dut, evq[0].is_done ? "done" : "tx_start", evq[0].cyc);
         evq.delete(0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
